// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the latency-configurable memory responder.
// Holds the FSM state encoding and the byte-merge helper used by the storage array.
package mem_responder_pkg;

  localparam int WORD_W        = 32;
  localparam int BE_W          = WORD_W / 8;
  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_LAT   = 2;
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Replace only the byte lanes selected by be; other lanes keep old_w.
  function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
// One request is outstanding at a time; ack qualifies err and rdata.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              busy;
  logic              ack;
  logic              err;
  logic [WORD_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  busy, ack, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output busy, ack, err, rdata
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word storage with byte-enabled synchronous write and combinational read.
// Contents survive reset; only the controller's state is cleared.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array; clearing a RAM would need a per-word sweep
  // and prevents mapping onto block memory.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[idx] <= byte_merge(mem[idx], wdata, be);
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one load/store at a time and acks it LAT cycles after
// acceptance, flagging misaligned or out-of-range addresses with err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LAT   = DEFAULT_LAT
) (
  input  logic Clk,
  input  logic R,
  mem_responder_if.slave bus
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              src_we;
  logic [WORD_W-1:0] src_addr;
  logic              src_err;
  logic [AW-1:0]     src_idx;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] resp_rdata;

  // In IDLE the live request drives the array so LAT=1 can respond next cycle;
  // otherwise the latched request does.
  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    src_we   = (state == IDLE) ? bus.we   : we_q;
    src_addr = (state == IDLE) ? bus.addr : addr_q;
    src_err  = (src_addr[1:0] != 2'b00) || (src_addr[WORD_W-1:AW+2] != '0);
    src_idx  = src_addr[AW+1:2];
    mem_wr   = (state == RESP) && we_q && !src_err && !R;
    resp_rdata = (!src_we && !src_err) ? mem_rdata : '0;
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .Clk   (Clk),
    .wr_en (mem_wr),
    .be    (be_q),
    .idx   (src_idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (R) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      // Response outputs are pulses: zero unless entering RESP this edge.
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            we_q     <= bus.we;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
            be_q     <= bus.be;
            bus.busy <= 1'b1;
            if (LAT == 1) begin
              state     <= RESP;
              bus.ack   <= 1'b1;
              bus.err   <= src_err;
              bus.rdata <= resp_rdata;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= RESP;
            bus.ack   <= 1'b1;
            bus.err   <= src_err;
            bus.rdata <= resp_rdata;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LAT=2 instance for function and reset checks,
// plus LAT=1 and LAT=7 instances for latency boundaries.
module tb_mem_responder;

  logic Clk = 1'b0;
  logic R   = 1'b1;
  always #5 Clk = ~Clk;

  mem_responder_if a_if ();
  mem_responder_if b_if ();
  mem_responder_if c_if ();

  mem_responder #(.DEPTH(64), .LAT(2)) dut_a (.Clk(Clk), .R(R), .bus(a_if));
  mem_responder #(.DEPTH(64), .LAT(1)) dut_b (.Clk(Clk), .R(R), .bus(b_if));
  mem_responder #(.DEPTH(64), .LAT(7)) dut_c (.Clk(Clk), .R(R), .bus(c_if));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One transaction on the LAT=2 instance, starting from an IDLE cycle.
  task automatic txn_a(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic exp_err, input logic [31:0] exp_rd,
                       input string tag);
    int lat;
    a_if.req = 1'b1; a_if.we = w; a_if.addr = a; a_if.wdata = wd; a_if.be = b;
    tick();
    a_if.req = 1'b0;
    check($sformatf("%s.busy_c1", tag), 32'(a_if.busy), 32'd1);
    check($sformatf("%s.err_c1", tag), 32'(a_if.err), 32'd0);
    check($sformatf("%s.rdata_c1", tag), a_if.rdata, 32'd0);
    lat = 1;
    while (a_if.ack !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check($sformatf("%s.latency", tag), 32'(lat), 32'd2);
    check($sformatf("%s.err", tag), 32'(a_if.err), 32'(exp_err));
    check($sformatf("%s.rdata", tag), a_if.rdata, exp_rd);
    tick();
    check($sformatf("%s.busy_after", tag), 32'(a_if.busy), 32'd0);
    check($sformatf("%s.ack_after", tag), 32'(a_if.ack), 32'd0);
  endtask

  // Same transaction issued to the LAT=1 and LAT=7 instances together.
  task automatic txn_bc(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string tag);
    int lat_b, lat_c;
    logic [31:0] rd_b, rd_c;
    lat_b = 0; lat_c = 0; rd_b = '0; rd_c = '0;
    b_if.req = 1'b1; b_if.we = w; b_if.addr = a; b_if.wdata = wd; b_if.be = 4'hF;
    c_if.req = 1'b1; c_if.we = w; c_if.addr = a; c_if.wdata = wd; c_if.be = 4'hF;
    tick();
    b_if.req = 1'b0;
    c_if.req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (b_if.ack === 1'b1 && lat_b == 0) begin lat_b = c; rd_b = b_if.rdata; end
      if (c_if.ack === 1'b1 && lat_c == 0) begin lat_c = c; rd_c = c_if.rdata; end
      tick();
    end
    check($sformatf("%s.lat1_latency", tag), 32'(lat_b), 32'd1);
    check($sformatf("%s.lat7_latency", tag), 32'(lat_c), 32'd7);
    check($sformatf("%s.lat1_rdata", tag), rd_b, exp_rd);
    check($sformatf("%s.lat7_rdata", tag), rd_c, exp_rd);
  endtask

  initial begin
    a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0; a_if.be = '0;
    b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0; b_if.be = '0;
    c_if.req = 0; c_if.we = 0; c_if.addr = '0; c_if.wdata = '0; c_if.be = '0;

    // Reset state
    R = 1'b1;
    tick(); tick();
    R = 1'b0;
    tick();
    check("rst.busy", 32'(a_if.busy), 32'd0);
    check("rst.ack", 32'(a_if.ack), 32'd0);
    check("rst.err", 32'(a_if.err), 32'd0);
    check("rst.rdata", a_if.rdata, 32'd0);

    // Full-word store then load
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "st10");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, "ld10");

    // Partial-byte store merges into the existing word
    txn_a(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, "st20");
    txn_a(1'b1, 32'h20, 32'h0000AA00, 4'h2, 1'b0, 32'h0, "st20_be2");
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h1122AA44, "ld20");

    // Misaligned and out-of-range accesses
    txn_a(1'b1, 32'h00, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, "st00");
    txn_a(1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0, "ld22_err");
    txn_a(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0, "ld100_err");
    txn_a(1'b1, 32'h101, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, "st101_err");
    txn_a(1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, "ld00_kept");

    // Store with no byte enables leaves the word alone
    txn_a(1'b1, 32'h10, 32'h01234567, 4'h0, 1'b0, 32'h0, "st10_be0");
    txn_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, "ld10_kept");

    // req held high: acks at cycles 2,5,8; busy low in cycles 3 and 6
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h10; a_if.be = 4'h0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) a_if.req = 1'b0;
      check($sformatf("hold.ack_c%0d", c), 32'(a_if.ack),
            32'((c == 2 || c == 5 || c == 8) ? 1 : 0));
      check($sformatf("hold.busy_c%0d", c), 32'(a_if.busy),
            32'((c == 3 || c == 6) ? 0 : 1));
      if (c == 2 || c == 5 || c == 8)
        check($sformatf("hold.rdata_c%0d", c), a_if.rdata, 32'hDEADBEEF);
    end
    tick();
    check("hold.busy_c9", 32'(a_if.busy), 32'd0);

    // Reset wins over a coincident request
    R = 1'b1;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h10;
    tick();
    R = 1'b0;
    a_if.req = 1'b0;
    check("rstreq.busy_c1", 32'(a_if.busy), 32'd0);
    tick();
    check("rstreq.busy_c2", 32'(a_if.busy), 32'd0);
    check("rstreq.ack_c2", 32'(a_if.ack), 32'd0);

    // Reset during WAIT aborts the store
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 32'h20; a_if.wdata = 32'hCAFEF00D; a_if.be = 4'hF;
    tick();
    a_if.req = 1'b0;
    R = 1'b1;
    check("abort.busy_c1", 32'(a_if.busy), 32'd1);
    tick();
    R = 1'b0;
    check("abort.busy_c2", 32'(a_if.busy), 32'd0);
    check("abort.ack_c2", 32'(a_if.ack), 32'd0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      check($sformatf("abort.ack_c%0d", c), 32'(a_if.ack), 32'd0);
    end
    txn_a(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h1122AA44, "ld20_after_abort");

    // Latency boundaries
    txn_bc(1'b1, 32'h4, 32'h13579BDF, 32'h0, "bc_st04");
    txn_bc(1'b0, 32'h4, 32'h0, 32'h13579BDF, "bc_ld04");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
